// File: rtl/fsm_sdr_side.sv
// rtl/fsm_sdr_side.sv - memory-side endpoint of the Wishbone egress/ingress FIFO pair
// Optional read watchdog: define FSM_SDR_WDOG_EN.
module fsm_sdr_side #(
  parameter int AW          = 24,
  parameter int DW          = 32,
  parameter int MAX_OUTST   = 4,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                     sdram_clk,
  input  logic                     sdram_rst_n,
  input  logic [2+DW/8+AW+DW-1:0]  egress_fifo_dat,
  input  logic                     egress_fifo_empty,
  output logic                     egress_fifo_re,
  output logic [DW-1:0]            ingress_fifo_dat,
  output logic                     ingress_fifo_we,
  input  logic                     ingress_fifo_full,
  output logic                     mem_cmd_valid,
  input  logic                     mem_cmd_ready,
  output logic                     mem_we,
  output logic                     mem_last,
  output logic [AW-1:0]            mem_adr,
  output logic [DW-1:0]            mem_dat_o,
  output logic [DW/8-1:0]          mem_sel,
  input  logic                     mem_rd_valid,
  output logic                     mem_rd_ready,
  input  logic [DW-1:0]            mem_rd_dat,
  output logic                     state_idle,
  output logic                     wdog_err
);

  localparam int SW = DW / 8;
  localparam logic [3:0] MAX_O = 4'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  state_t     state;
  logic [3:0] outst;
  logic       accept;
  logic       rd_acc;
  logic       beat;
  logic       dec;
  logic       wdog_hit;

  // Command fields are a zero-latency view of the FWFT egress head.
  assign mem_dat_o = egress_fifo_dat[DW-1:0];
  assign mem_adr   = egress_fifo_dat[DW +: AW];
  assign mem_sel   = egress_fifo_dat[DW+AW +: SW];
  assign mem_last  = egress_fifo_dat[DW+AW+SW];
  assign mem_we    = egress_fifo_dat[DW+AW+SW+1];

  always_comb begin
    mem_cmd_valid = 1'b0;
    case (state)
      WR:      mem_cmd_valid = !egress_fifo_empty;
      RD:      mem_cmd_valid = !egress_fifo_empty && (outst < MAX_O);
      default: mem_cmd_valid = 1'b0;
    endcase
  end

  assign accept           = mem_cmd_valid & mem_cmd_ready;
  assign egress_fifo_re   = accept;
  assign rd_acc           = accept & (state == RD);
  assign mem_rd_ready     = !ingress_fifo_full;
  assign beat             = mem_rd_valid & mem_rd_ready;
  assign ingress_fifo_we  = beat;
  assign ingress_fifo_dat = mem_rd_dat;
  // A stray beat with nothing outstanding is still pushed but never underflows the count.
  assign dec              = beat & (outst != 4'd0);

`ifdef FSM_SDR_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wcnt;
  logic          stall;

  assign stall    = ((state == RD) || (state == DRAIN)) && (outst != 4'd0) && !beat;
  assign wdog_hit = stall && (wcnt == CW'(WDOG_CYCLES - 1));
  assign wdog_err = wdog_hit;

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      wcnt <= '0;
    end else if (beat || (outst == 4'd0) || wdog_hit) begin
      wcnt <= '0;
    end else if (stall) begin
      wcnt <= wcnt + CW'(1);
    end
  end
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES == 0);
  assign wdog_hit    = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      outst <= 4'd0;
    end else if (wdog_hit) begin
      outst <= 4'd0;
    end else if (rd_acc && !dec) begin
      outst <= outst + 4'd1;
    end else if (dec && !rd_acc) begin
      outst <= outst - 4'd1;
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state      <= IDLE;
      state_idle <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!egress_fifo_empty) begin
            state      <= mem_we ? WR : RD;
            state_idle <= 1'b0;
          end
        end
        WR: begin
          if (accept && mem_last) begin
            state      <= IDLE;
            state_idle <= 1'b1;
          end
        end
        RD: begin
          if (accept && mem_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((outst == 4'd0) || wdog_hit) begin
            state      <= IDLE;
            state_idle <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          state_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule
